serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_add_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_serial_add_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and default width for the serial adder controller
package serial_add_pkg;

    localparam int SERIAL_ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_cell.sv
// rtl/serial_add_cell.sv - combinational 1-bit full adder used as the serial adder cell
module serial_add_cell (
    input  logic x1,
    input  logic x2,
    input  logic y,
    output logic z,
    output logic ny
);

    assign z  = x1 ^ x2 ^ y;
    assign ny = (x1 & x2) | (x1 & y) | (x2 & y);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - LSB-first serial addition sequencer; SERIAL_ADD_CTRL_OVF_EN adds the ovf output
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             cp,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               s;
    logic               ny;
    logic               last;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    serial_add_cell u_cell (
        .x1 (a_sr[0]),
        .x2 (b_sr[0]),
        .y  (carry),
        .z  (s),
        .ny (ny)
    );

    always_ff @(negedge cp or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Carry is only written on accept and in SHIFT, so it doubles as the held cout.
    always_ff @(negedge cp or negedge clr_n) begin
        if (!clr_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && start) begin
            a_sr   <= a;
            b_sr   <= b;
            sum_sr <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {s, sum_sr[WIDTH-1:1]};
            carry  <= ny;
            cnt    <= cnt + 1'b1;
        end
    end

`ifdef SERIAL_ADD_CTRL_OVF_EN
    // On the last shift, carry holds the carry into the MSB and ny the carry out.
    always_ff @(negedge cp or negedge clr_n) begin
        if (!clr_n) begin
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && last) begin
            ovf <= carry ^ ny;
        end
    end
`endif

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl (optionally with SERIAL_ADD_CTRL_OVF_EN)
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;
    localparam int BOUND = 200;

    logic             cp;
    logic             clr_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    logic             ovf;
`endif

    // {ovf, cout, sum}
    logic [WIDTH+1:0] exp_q[$];
    int               n_cmp;
    int               n_err;
    int               done_cnt;
    int               busy_cnt;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .cp    (cp),
        .clr_n (clr_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_CTRL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial begin
        cp = 1'b1;
        forever #5 cp = ~cp;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DUT registers update on the falling edge; the monitor samples on the rising edge.
    initial begin
        logic [WIDTH+1:0] e;
        forever begin
            @(posedge cp);
            if (!clr_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'(sum), 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("sum_cout", 64'({cout, sum}), 64'(e[WIDTH:0]));
`ifdef SERIAL_ADD_CTRL_OVF_EN
                        check("ovf", 64'(ovf), 64'(e[WIDTH+1]));
`endif
                        check("busy_cycles", 64'(busy_cnt), 64'(WIDTH));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < BOUND; i++) begin
            if (!busy && !done) break;
            @(posedge cp);
            #1;
        end
        if (i == BOUND) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_done(input int target);
        int i;
        for (i = 0; i < BOUND; i++) begin
            @(posedge cp);
            #1;
            if (done_cnt >= target) break;
        end
        if (i == BOUND) check("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tcin, input logic [WIDTH+1:0] exp);
        wait_idle();
        a     = ta;
        b     = tb_;
        cin   = tcin;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge cp);
        start = 1'b0;
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             ovf;
        logic             cout;
        logic [WIDTH-1:0] sum;
    } vec_t;

    vec_t vecs[5] = '{
        '{8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h96},
        '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00},
        '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01},
        '{8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h80},
        '{8'hAA, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00}
    };

    initial begin
        int target;
        n_cmp    = 0;
        n_err    = 0;
        done_cnt = 0;
        busy_cnt = 0;
        clr_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        @(posedge cp);
        @(posedge cp);
        check("reset_outputs", 64'({busy, done, cout, sum}), 64'(0));
`ifdef SERIAL_ADD_CTRL_OVF_EN
        check("reset_ovf", 64'(ovf), 64'(0));
`endif
        clr_n = 1'b1;
        @(posedge cp);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin,
                  {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
            a   = ~vecs[i].a;
            b   = ~vecs[i].b;
            cin = ~vecs[i].cin;
            wait_done(i + 1);
        end

        // start during SHIFT is ignored
        issue(8'h11, 8'h22, 1'b0, {1'b0, 1'b0, 8'h33});
        @(posedge cp);
        @(posedge cp);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge cp);
        start = 1'b0;
        target = done_cnt + 1;
        wait_done(target);
        repeat (2 * WIDTH) @(posedge cp);
        #1;
        check("single_done", 64'(done_cnt), 64'(target));
        check("queue_empty_ignored", 64'(exp_q.size()), 64'(0));

        // start held high gives back-to-back additions
        wait_idle();
        exp_q.push_back({1'b0, 1'b0, 8'h07});
        exp_q.push_back({1'b0, 1'b0, 8'h07});
        a      = 8'h03;
        b      = 8'h04;
        cin    = 1'b0;
        start  = 1'b1;
        target = done_cnt + 2;
        wait_done(target);
        start = 1'b0;

        // reset mid-operation aborts without a done pulse
        wait_idle();
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge cp);
        start = 1'b0;
        repeat (3) @(posedge cp);
        target = done_cnt;
        clr_n  = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sum", 64'(sum), 64'(0));
        check("abort_cout", 64'(cout), 64'(0));
        @(posedge cp);
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 8'h02});
        @(posedge cp);
        clr_n = 1'b1;
        @(posedge cp);
        start = 1'b0;
        #1;
        check("accept_after_release", 64'(busy), 64'(1));
        wait_done(target + 1);
        check("no_done_on_abort", 64'(done_cnt), 64'(target + 1));

        wait_idle();
        repeat (2) @(posedge cp);
        check("queue_empty_final", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
